// File: rtl/lcd_write_engine_if.sv
// LSU-side port of the LCD write engine: one-cycle command strobe in, polled status word out.
interface lcd_write_engine_if;
  logic        i_wr_stb;
  logic [31:0] i_wr_data;
  logic [31:0] o_status;

  modport master (output i_wr_stb, output i_wr_data, input o_status);
  modport slave  (input i_wr_stb, input i_wr_data, output o_status);
endinterface

// File: rtl/lcd_write_engine.sv
// Buffers LSU command words and replays each as a timed HD44780 8-bit write cycle.
// One down-counter times SETUP/PULSE/HOLD/EXEC; RS/DATA only change at pop.
module lcd_write_engine #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_SETUP     = 2,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  lcd_write_engine_if.slave  bus,
  output logic [7:0]         o_lcd_data,
  output logic               o_lcd_rs,
  output logic               o_lcd_rw,
  output logic               o_lcd_en,
  output logic               o_lcd_on
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TM1  = (T_EXEC_LONG > T_EXEC) ? T_EXEC_LONG : T_EXEC;
  localparam int TM2  = (T_EN > T_SETUP) ? T_EN : T_SETUP;
  localparam int TM3  = (TM2 > T_HOLD) ? TM2 : T_HOLD;
  localparam int TMAX = (TM1 > TM3) ? TM1 : TM3;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          ovf, full, empty, busy, push, pop, long_cmd, en_nxt;
  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  entry_t        wr_entry;
  logic          unused_wr_bits;

  assign wr_entry       = '{rs: bus.i_wr_data[9], data: bus.i_wr_data[7:0]};
  assign unused_wr_bits = ^{bus.i_wr_data[30:10], bus.i_wr_data[8]};

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != IDLE) || !empty;
  assign pop   = (state == IDLE) && !empty;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push  = bus.i_wr_stb && (!full || pop);

  // Clear and return-home need the long execution wait.
  assign long_cmd = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data[1:0] != 2'd0);

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= wr_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (bus.i_wr_stb && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      IDLE: if (!empty) begin
        nstate = SETUP;
        ncnt   = CW'(T_SETUP - 1);
      end
      SETUP: if (cnt == '0) begin
        nstate = PULSE;
        ncnt   = CW'(T_EN - 1);
      end else ncnt = cnt - 1'b1;
      PULSE: if (cnt == '0) begin
        nstate = HOLD;
        ncnt   = CW'(T_HOLD - 1);
      end else ncnt = cnt - 1'b1;
      HOLD: if (cnt == '0) begin
        nstate = EXEC;
        ncnt   = long_cmd ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
      end else ncnt = cnt - 1'b1;
      EXEC: if (cnt == '0) nstate = IDLE;
            else ncnt = cnt - 1'b1;
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // EN is registered so it is glitch-free on the pin and tracks the PULSE state exactly.
  always_comb begin
    en_nxt = (nstate == PULSE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'd0;
      o_lcd_on   <= 1'b0;
    end else begin
      o_lcd_en <= en_nxt;
      if (pop) {o_lcd_rs, o_lcd_data} <= mem[rptr];
      if (bus.i_wr_stb) o_lcd_on <= bus.i_wr_data[31];
    end
  end

  assign o_lcd_rw   = 1'b0;
  assign bus.o_status = {29'd0, ovf, full, busy};
endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine: timeline model of each write cycle plus literal timing checks.
module tb_lcd_write_engine;
  localparam int DEPTH = 4, TS = 2, TE = 4, TH = 2, TX = 10, TXL = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  lcd_write_engine_if bus();
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

  lcd_write_engine #(
    .FIFO_DEPTH(DEPTH), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_en(lcd_en), .o_lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: an entry popped at edge P occupies P..P+D; EN is high for t in [TS, TS+TE).
  logic [8:0] mq[$];
  bit         m_act;
  int         m_t, m_d;
  logic       m_rs, m_on, m_ovf;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_act = 0; m_t = 0; m_d = 0;
      m_rs = 0; m_data = 0; m_on = 0; m_ovf = 0;
    end else begin
      bit pop_now, full_now;
      pop_now  = !m_act && mq.size() > 0;
      full_now = mq.size() == DEPTH;
      if (m_act) begin
        m_t++;
        if (m_t == m_d) m_act = 0;
      end else if (pop_now) begin
        {m_rs, m_data} = mq.pop_front();
        m_act = 1;
        m_t   = 0;
        m_d   = TS + TE + TH + ((!m_rs && m_data inside {8'h01, 8'h02, 8'h03}) ? TXL : TX);
      end
      if (bus.i_wr_stb) begin
        m_on = bus.i_wr_data[31];
        if (!full_now || pop_now) mq.push_back({bus.i_wr_data[9], bus.i_wr_data[7:0]});
        else m_ovf = 1;
      end
    end
  end

  logic [7:0] rise_q[$];
  logic       prev_en = 1'b0;

  always @(negedge clk) begin
    logic [31:0] st;
    logic        exp_en;
    st     = {29'd0, m_ovf, mq.size() == DEPTH, m_act || mq.size() != 0};
    exp_en = m_act && m_t >= TS && m_t < TS + TE;
    chk("model_status", bus.o_status, st);
    chk("model_pins", {20'd0, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_data},
                      {20'd0, exp_en, m_rs, 1'b0, m_on, m_data});
    if (lcd_en && !prev_en) rise_q.push_back(lcd_data);
    prev_en = lcd_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d);
    bus.i_wr_stb  = 1'b1;
    bus.i_wr_data = d;
    tick();
    bus.i_wr_stb  = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (bus.o_status[0] && c < 500) begin tick(); c++; end
    if (c >= 500) chk("idle_timeout", 32'(bus.o_status[0]), 32'd0);
  endtask

  task automatic busy_len(input logic [31:0] d, input int exp, input string nm);
    int c;
    strobe(d);
    c = 0;
    while (bus.o_status[0] && c < 300) begin tick(); c++; end
    chk(nm, c, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    bus.i_wr_stb  = 1'b0;
    bus.i_wr_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_status", bus.o_status, 32'd0);
    chk("reset_pins", {20'd0, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_data}, 32'd0);

    // Single data write: exact EN window and busy length.
    strobe(32'h8000_0241);
    chk("t1_on", 32'(lcd_on), 32'd1);
    chk("t1_busy0", bus.o_status, 32'd1);
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk("t1_en", 32'(lcd_en), 32'(k >= 3 && k <= 6));
      if (k == 1) chk("t1_rsdata", 32'({lcd_rs, lcd_data}), 32'h141);
      chk("t1_busy", 32'(bus.o_status[0]), 32'(k < 19));
    end

    // Clear command runs the long wait.
    busy_len(32'h0000_0001, 1 + TS + TE + TH + TXL, "clr_busy_len");
    chk("clr_rsdata", 32'({lcd_rs, lcd_data}), 32'h001);

    // Follow-up during EXEC pops only after IDLE.
    strobe(32'h0000_0001);
    repeat (19) tick();
    strobe(32'h0000_0038);
    repeat (39) tick();
    chk("clr_follow_hold", 32'(lcd_data), 32'h01);
    chk("clr_follow_busy", bus.o_status, 32'd1);
    tick();
    chk("clr_follow_pop", 32'(lcd_data), 32'h38);
    wait_idle();

    // Burst of 6: one in flight, four buffered, one dropped.
    rise_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus.i_wr_stb  = 1'b1;
      bus.i_wr_data = 32'h241 + i;
      tick();
      if (i == 4) chk("burst_full", bus.o_status, 32'd3);
      if (i == 5) chk("burst_ovf", bus.o_status, 32'd7);
    end
    bus.i_wr_stb = 1'b0;
    wait_idle();
    chk("burst_pulses", rise_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < rise_q.size(); i++)
      chk("burst_order", 32'(rise_q[i]), 32'h41 + i);
    chk("burst_ovf_sticky", bus.o_status, 32'd4);

    // Full FIFO plus same-cycle pop accepts the strobe.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_stb  = 1'b1;
      bus.i_wr_data = 32'h241 + i;
      tick();
    end
    bus.i_wr_stb = 1'b0;
    repeat (15) tick();
    chk("fullpop_pre", bus.o_status, 32'd3);
    strobe(32'h0000_0250);
    chk("fullpop_post", bus.o_status, 32'd3);
    chk("fullpop_data", 32'(lcd_data), 32'h42);
    wait_idle();
    chk("fullpop_noovf", bus.o_status, 32'd0);

    // Reset while EN is high drops everything without a clock edge.
    strobe(32'h8000_0255);
    c = 0;
    while (!lcd_en && c < 50) begin tick(); c++; end
    chk("rst_en_seen", 32'(lcd_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_pins", {20'd0, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_data}, 32'd0);
    chk("rst_async_status", bus.o_status, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    rise_q.delete();
    repeat (30) tick();
    chk("rst_no_pulse", rise_q.size(), 32'd0);

    // Long-wait decode boundaries.
    busy_len(32'h0000_0002, 1 + TS + TE + TH + TXL, "home02_len");
    busy_len(32'h0000_0003, 1 + TS + TE + TH + TXL, "home03_len");
    busy_len(32'h0000_0000, 1 + TS + TE + TH + TX, "cmd00_len");
    busy_len(32'h0000_0004, 1 + TS + TE + TH + TX, "cmd04_len");
    busy_len(32'h0000_0201, 1 + TS + TE + TH + TX, "data01_len");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
